// File: rtl/prog_loader.sv
// Boot-time program loader: parses framed host bytes, writes 16-bit words into
// program memory, and holds the CPU in reset until a frame checks out.
module prog_loader #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic [7:0]  i_byte,
    input  logic        i_byte_valid,
    output logic        o_byte_ready,
    output logic        o_mem_we,
    output logic [15:0] o_mem_addr,
    output logic [15:0] o_mem_data,
    output logic        o_cpu_hold,
    output logic        o_done,
    output logic        o_error
);

    localparam logic [3:0] IDLE  = 4'd0;
    localparam logic [3:0] CNT_L = 4'd1;
    localparam logic [3:0] CNT_H = 4'd2;
    localparam logic [3:0] ADR_L = 4'd3;
    localparam logic [3:0] ADR_H = 4'd4;
    localparam logic [3:0] DAT_L = 4'd5;
    localparam logic [3:0] DAT_H = 4'd6;
    localparam logic [3:0] CHK   = 4'd7;
    localparam logic [3:0] DONE  = 4'd8;
    localparam logic [3:0] ERR   = 4'd9;

    logic [3:0]  state;
    logic [7:0]  csum;
    logic [7:0]  lo_byte;
    logic [15:0] words_left;
    logic [15:0] cur_addr;
    logic        accept;
    logic        at_rest;

    // The loader never back-pressures the host; ready only drops during reset.
    assign o_byte_ready = ~i_reset;
    assign accept       = i_byte_valid & o_byte_ready;
    assign at_rest      = (state == IDLE) || (state == DONE) || (state == ERR);

    // Datapath holding registers: only meaningful once loaded by the header.
    always_ff @(posedge i_clock) begin
        if (accept) begin
            case (state)
                CNT_L, ADR_L, DAT_L: lo_byte <= i_byte;
                CNT_H:               words_left <= {i_byte, lo_byte};
                ADR_H:               cur_addr <= {i_byte, lo_byte};
                DAT_H: begin
                    words_left <= words_left - 16'd1;
                    cur_addr   <= cur_addr + 16'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state      <= IDLE;
            csum       <= 8'h00;
            o_mem_we   <= 1'b0;
            o_mem_addr <= 16'h0000;
            o_mem_data <= 16'h0000;
            o_cpu_hold <= 1'b1;
            o_done     <= 1'b0;
            o_error    <= 1'b0;
        end else begin
            o_mem_we <= 1'b0;
            if (accept) begin
                case (state)
                    CNT_L: state <= CNT_H;
                    CNT_H: state <= ADR_L;
                    ADR_L: state <= ADR_H;
                    // An empty frame skips straight to the checksum byte.
                    ADR_H: state <= (words_left == 16'd0) ? CHK : DAT_L;
                    DAT_L: begin
                        csum  <= csum ^ i_byte;
                        state <= DAT_H;
                    end
                    DAT_H: begin
                        csum       <= csum ^ i_byte;
                        o_mem_we   <= 1'b1;
                        o_mem_addr <= cur_addr;
                        o_mem_data <= {i_byte, lo_byte};
                        state      <= (words_left == 16'd1) ? CHK : DAT_L;
                    end
                    CHK: begin
                        if (i_byte == csum) begin
                            state      <= DONE;
                            o_done     <= 1'b1;
                            o_cpu_hold <= 1'b0;
                        end else begin
                            state   <= ERR;
                            o_error <= 1'b1;
                        end
                    end
                    default: begin
                        // IDLE, DONE, ERR: only a sync byte starts a new frame.
                        if (at_rest && (i_byte == SYNC_BYTE)) begin
                            state      <= CNT_L;
                            csum       <= 8'h00;
                            o_cpu_hold <= 1'b1;
                            o_done     <= 1'b0;
                            o_error    <= 1'b0;
                        end else if (!at_rest) begin
                            state <= IDLE;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected memory writes are queued as data
// bytes are driven and popped whenever the loader strobes o_mem_we.
module tb_prog_loader;

    logic        i_clock = 1'b0;
    logic        i_reset = 1'b1;
    logic [7:0]  i_byte = 8'h00;
    logic        i_byte_valid = 1'b0;
    logic        o_byte_ready;
    logic        o_mem_we;
    logic [15:0] o_mem_addr;
    logic [15:0] o_mem_data;
    logic        o_cpu_hold;
    logic        o_done;
    logic        o_error;

    prog_loader #(.SYNC_BYTE(8'hA5)) dut (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_byte       (i_byte),
        .i_byte_valid (i_byte_valid),
        .o_byte_ready (o_byte_ready),
        .o_mem_we     (o_mem_we),
        .o_mem_addr   (o_mem_addr),
        .o_mem_data   (o_mem_data),
        .o_cpu_hold   (o_cpu_hold),
        .o_done       (o_done),
        .o_error      (o_error)
    );

    always #5 i_clock = ~i_clock;

    int          errors = 0;
    int          checks = 0;
    int          writes = 0;
    bit          gaps = 1'b0;
    logic [31:0] exp_q[$];
    logic [15:0] frame_w[$];

    task automatic observe();
        logic [31:0] e;
        if (o_mem_we === 1'b1) begin
            writes++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%h data=%h, required no write", o_mem_addr, o_mem_data);
            end else begin
                e = exp_q.pop_front();
                if ({o_mem_addr, o_mem_data} !== e)
                begin
                    errors++;
                    $display("FAIL mem_write: got addr=%h data=%h, required addr=%h data=%h",
                             o_mem_addr, o_mem_data, e[31:16], e[15:0]);
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge i_clock);
        #1;
        observe();
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        if (gaps) begin
            n = $urandom_range(0, 2);
            repeat (n) begin
                i_byte_valid = 1'b0;
                i_byte = 8'($urandom);
                tick();
            end
        end
        i_byte = b;
        i_byte_valid = 1'b1;
        tick();
        i_byte_valid = 1'b0;
    endtask

    // Sends a whole frame built from frame_w; checksum is the XOR of data bytes.
    task automatic send_frame(input logic [15:0] start, input bit corrupt);
        logic [7:0]  x;
        logic [15:0] a;
        logic [15:0] n;
        logic [2:0]  flags;
        int          w0;
        x = 8'h00;
        a = start;
        n = 16'(frame_w.size());
        w0 = writes;
        send(8'hA5);
        checks++;
        if ({o_cpu_hold, o_done, o_error, o_byte_ready} !== 4'b1001) begin
            errors++;
            $display("FAIL sync_flags: got hold/done/err/rdy=%b, required 1001",
                     {o_cpu_hold, o_done, o_error, o_byte_ready});
        end
        send(n[7:0]);
        send(n[15:8]);
        send(start[7:0]);
        send(start[15:8]);
        foreach (frame_w[i]) begin
            x = x ^ frame_w[i][7:0] ^ frame_w[i][15:8];
            send(frame_w[i][7:0]);
            exp_q.push_back({a, frame_w[i]});
            send(frame_w[i][15:8]);
            a = a + 16'd1;
        end
        send(corrupt ? (x ^ 8'h01) : x);
        flags = corrupt ? 3'b011 : 3'b100;
        checks++;
        if ({o_done, o_error, o_cpu_hold} !== flags) begin
            errors++;
            $display("FAIL frame_status: got done/err/hold=%b, required %b",
                     {o_done, o_error, o_cpu_hold}, flags);
        end
        tick();
        tick();
        checks++;
        if (exp_q.size() != 0 || (writes - w0) != frame_w.size()) begin
            errors++;
            $display("FAIL write_count: got %0d writes (%0d pending), required %0d",
                     writes - w0, exp_q.size(), frame_w.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        i_byte_valid = 1'b1;
        i_byte = 8'hA5;
        repeat (2) @(posedge i_clock);
        #1;
        checks++;
        if ({o_byte_ready, o_mem_we, o_cpu_hold, o_done, o_error} !== 5'b00100) begin
            errors++;
            $display("FAIL reset_ctrl: got rdy/we/hold/done/err=%b, required 00100",
                     {o_byte_ready, o_mem_we, o_cpu_hold, o_done, o_error});
        end
        checks++;
        if ({o_mem_addr, o_mem_data} !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got addr=%h data=%h, required 0000 0000", o_mem_addr, o_mem_data);
        end
        i_byte_valid = 1'b0;
        i_reset = 1'b0;
        #1;
        checks++;
        if (o_byte_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got %b, required 1", o_byte_ready);
        end
    endtask

    task automatic test_ignore();
        int w0;
        w0 = writes;
        send(8'h00);
        send(8'hFF);
        send(8'h13);
        checks++;
        if ({o_cpu_hold, o_done, o_error} !== 3'b100 || writes != w0) begin
            errors++;
            $display("FAIL idle_ignore: got hold/done/err=%b writes=%0d, required 100 writes=0",
                     {o_cpu_hold, o_done, o_error}, writes - w0);
        end
    endtask

    task automatic test_basic();
        frame_w = '{16'h1234, 16'h5678};
        send_frame(16'h0010, 1'b0);
    endtask

    task automatic test_bad_then_empty();
        frame_w = '{16'h1234, 16'h5678};
        send_frame(16'h0010, 1'b1);
        frame_w = '{};
        send_frame(16'h0000, 1'b0);
    endtask

    task automatic test_wrap();
        frame_w = '{16'h0001, 16'h0002};
        send_frame(16'hFFFF, 1'b0);
    endtask

    task automatic test_sync_as_data();
        frame_w = '{16'hA5A5, 16'h00A5, 16'hA500};
        send_frame(16'hA5A5, 1'b0);
    endtask

    task automatic test_reset_mid();
        int w0;
        w0 = writes;
        send(8'hA5);
        send(8'h02);
        send(8'h00);
        send(8'h10);
        send(8'h00);
        send(8'h34);
        i_byte = 8'h12;
        i_byte_valid = 1'b1;
        @(posedge i_clock);
        #1;
        i_reset = 1'b1;
        i_byte_valid = 1'b0;
        #1;
        checks++;
        if ({o_byte_ready, o_mem_we, o_cpu_hold, o_done, o_error} !== 5'b00100) begin
            errors++;
            $display("FAIL reset_mid_ctrl: got rdy/we/hold/done/err=%b, required 00100",
                     {o_byte_ready, o_mem_we, o_cpu_hold, o_done, o_error});
        end
        checks++;
        if ({o_mem_addr, o_mem_data} !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_data: got addr=%h data=%h, required 0000 0000", o_mem_addr, o_mem_data);
        end
        tick();
        i_reset = 1'b0;
        repeat (3) tick();
        checks++;
        if (writes != w0 || o_cpu_hold !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_writes: got %0d writes hold=%b, required 0 writes hold=1",
                     writes - w0, o_cpu_hold);
        end
        exp_q.delete();
    endtask

    task automatic test_gaps();
        gaps = 1'b1;
        frame_w = '{16'h1234, 16'h5678};
        send_frame(16'h0010, 1'b0);
        gaps = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ignore();
        test_basic();
        test_bad_then_empty();
        test_wrap();
        test_sync_as_data();
        test_reset_mid();
        test_gaps();
        test_basic();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
